// File: rtl/seq_multi_adder.sv
`default_nettype none
// ============================================================================
// Module   : seq_multi_adder
// Purpose  : Sequential multi-operand adder. Accepts NUM_OPS unsigned
//            WIDTH-bit operands, one per accepted beat, over a valid/ready
//            stream. It accumulates them and presents the full-precision sum,
//            a WIDTH-bit saturated copy and an overflow flag.
// Ports    : clk       - clock, rising edge
//            rst_n     - asynchronous active-low reset
//            clear     - synchronous abort of the current transaction
//            in_valid  - operand valid
//            in_ready  - block can accept an operand
//            in_data   - operand, unsigned WIDTH bits
//            op_cnt    - operands accepted in current transaction
//            out_valid - result valid
//            out_ready - downstream accepts result
//            out_sum   - full-precision sum (SUMW bits)
//            out_sat   - sum clamped to 2^WIDTH-1
//            out_ovf   - 1 when out_sum exceeds 2^WIDTH-1
// Revision : 1.0 - initial release
// ============================================================================
module seq_multi_adder #(
   parameter  int WIDTH   = 4,
   parameter  int NUM_OPS = 4,
   localparam int SUMW    = WIDTH + $clog2(NUM_OPS),
   localparam int CNTW    = $clog2(NUM_OPS) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic [CNTW-1:0]  op_cnt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SUMW-1:0]  out_sum,
   output logic [WIDTH-1:0] out_sat,
   output logic             out_ovf
);

   localparam logic [0:0]      c_state_acc = 1'b0;
   localparam logic [0:0]      c_state_out = 1'b1;
   localparam logic [CNTW-1:0] c_last_idx  = CNTW'(NUM_OPS - 1);

   logic [0:0]      r_state;
   logic [0:0]      w_state_nxt;
   logic            r_run;
   logic [SUMW-1:0] r_acc;
   logic [CNTW-1:0] r_cnt;
   logic [SUMW-1:0] r_sum;
   logic            w_accept;
   logic            w_last;
   logic            w_release;
   logic [SUMW-1:0] w_acc_nxt;

   // in_ready is held low while in reset and goes high on the first edge
   // after release; r_run provides that one-edge qualification.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_run <= 1'b0;
      end else begin
         r_run <= 1'b1;
      end
   end

   // clear overrides both the operand accept and the result handshake.
   assign w_accept  = in_valid && in_ready && !clear;
   assign w_last    = (r_cnt == c_last_idx);
   assign w_release = (r_state == c_state_out) && out_ready && !clear;
   assign w_acc_nxt = r_acc + {{(SUMW-WIDTH){1'b0}}, in_data};

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_state_acc;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (clear) begin
         w_state_nxt = c_state_acc;
      end else begin
         case (r_state)
            c_state_acc: if (w_accept && w_last) w_state_nxt = c_state_out;
            c_state_out: if (out_ready)          w_state_nxt = c_state_acc;
            default:                             w_state_nxt = c_state_acc;
         endcase
      end
   end

   always_comb begin
      in_ready  = (r_state == c_state_acc) && r_run;
      out_valid = (r_state == c_state_out);
   end

   // ----------------------------------------------------------- datapath
   // r_sum is only updated on the final accept so that the result stays on
   // out_sum after the handshake until the next transaction completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_sum <= '0;
      end else if (clear) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (w_accept) begin
         r_acc <= w_acc_nxt;
         r_cnt <= r_cnt + CNTW'(1);
         if (w_last) begin
            r_sum <= w_acc_nxt;
         end
      end else if (w_release) begin
         r_acc <= '0;
         r_cnt <= '0;
      end
   end

   // SUMW > WIDTH always holds because NUM_OPS >= 2, so any set bit above
   // the operand width means the sum no longer fits in WIDTH bits.
   assign out_ovf = |r_sum[SUMW-1:WIDTH];
   assign out_sat = out_ovf ? {WIDTH{1'b1}} : r_sum[WIDTH-1:0];
   assign out_sum = r_sum;
   assign op_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_seq_multi_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_multi_adder
// Purpose  : Self-checking bench for seq_multi_adder (WIDTH=4, NUM_OPS=4).
//            Expected sums are queued as operands are driven and compared
//            when the result appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_multi_adder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clear;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic [2:0] op_cnt;
   logic       out_valid;
   logic       out_ready;
   logic [5:0] out_sum;
   logic [3:0] out_sat;
   logic       out_ovf;

   int checks = 0;
   int errors = 0;
   int exp_q[$];
   int model_acc = 0;
   int model_cnt = 0;

   seq_multi_adder #(.WIDTH(4), .NUM_OPS(4)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .op_cnt(op_cnt), .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_sat(out_sat), .out_ovf(out_ovf)
   );

   always #5 clk = ~clk;

   task automatic send_op(input int d);
      int  n = 0;
      logic [2:0] exp_cnt;
      logic exp_v;
      in_valid = 1'b1;
      in_data  = d[3:0];
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (!in_ready) begin
         errors++;
         $display("FAIL send_op_ready: in_ready=%0b required 1", in_ready);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      model_acc = model_acc + d;
      model_cnt = model_cnt + 1;
      exp_cnt   = model_cnt[2:0];
      exp_v     = (model_cnt == 4);
      checks++;
      if (op_cnt !== exp_cnt) begin
         errors++;
         $display("FAIL op_cnt: got %0d required %0d", op_cnt, exp_cnt);
      end
      checks++;
      if (out_valid !== exp_v) begin
         errors++;
         $display("FAIL out_valid_latency: got %0b required %0b", out_valid, exp_v);
      end
      if (model_cnt == 4) begin
         exp_q.push_back(model_acc);
         model_acc = 0;
         model_cnt = 0;
      end
   endtask

   task automatic collect();
      int n = 0;
      int e;
      logic [5:0] e_sum;
      logic [3:0] e_sat;
      logic       e_ovf;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (!out_valid) begin
         errors++;
         $display("FAIL collect_timeout: out_valid=%0b required 1", out_valid);
         return;
      end
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty: result %0d with nothing expected", out_sum);
         return;
      end
      e     = exp_q.pop_front();
      e_sum = e[5:0];
      e_ovf = (e > 15);
      e_sat = e_ovf ? 4'hF : e_sum[3:0];
      checks++;
      if (out_sum !== e_sum) begin
         errors++;
         $display("FAIL out_sum: got %0d required %0d", out_sum, e_sum);
      end
      checks++;
      if (out_sat !== e_sat) begin
         errors++;
         $display("FAIL out_sat: got %0d required %0d", out_sat, e_sat);
      end
      checks++;
      if (out_ovf !== e_ovf) begin
         errors++;
         $display("FAIL out_ovf: got %0b required %0b", out_ovf, e_ovf);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || op_cnt !== 3'd0) begin
         errors++;
         $display("FAIL handshake: out_valid=%0b op_cnt=%0d required 0 0", out_valid, op_cnt);
      end
      checks++;
      if (out_sum !== e_sum) begin
         errors++;
         $display("FAIL sum_hold: got %0d required %0d", out_sum, e_sum);
      end
   endtask

   task automatic test_reset();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_sum !== 6'd0 ||
          out_sat !== 4'd0 || out_ovf !== 1'b0 || op_cnt !== 3'd0) begin
         errors++;
         $display("FAIL reset_values: rdy=%0b vld=%0b sum=%0d sat=%0d ovf=%0b cnt=%0d required all 0",
                  in_ready, out_valid, out_sum, out_sat, out_ovf, op_cnt);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_reset: got %0b required 1", in_ready);
      end
   endtask

   task automatic test_sum(input int a, input int b, input int c, input int d);
      send_op(a); send_op(b); send_op(c); send_op(d);
      collect();
   endtask

   task automatic test_backpressure();
      send_op(9); send_op(8); send_op(7); send_op(6);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 4'd5;
      repeat (5) begin
         @(posedge clk); #1;
         checks++;
         if (in_ready !== 1'b0 || op_cnt !== 3'd4 || out_sum !== 6'd30 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL backpressure: rdy=%0b cnt=%0d sum=%0d vld=%0b required 0 4 30 1",
                     in_ready, op_cnt, out_sum, out_valid);
         end
      end
      in_valid = 1'b0;
      collect();
   endtask

   task automatic test_clear();
      send_op(6); send_op(6);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_data  = 4'd6;
      @(posedge clk); #1;
      clear     = 1'b0;
      in_valid  = 1'b0;
      model_acc = 0;
      model_cnt = 0;
      checks++;
      if (op_cnt !== 3'd0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL clear: cnt=%0d vld=%0b required 0 0", op_cnt, out_valid);
      end
      test_sum(1, 1, 1, 1);
   endtask

   task automatic test_async_reset();
      send_op(3); send_op(3);
      #3;
      rst_n = 1'b0;
      #1;
      model_acc = 0;
      model_cnt = 0;
      checks++;
      if (op_cnt !== 3'd0 || out_valid !== 1'b0 || out_sum !== 6'd0 ||
          out_sat !== 4'd0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: cnt=%0d vld=%0b sum=%0d sat=%0d rdy=%0b required all 0",
                  op_cnt, out_valid, out_sum, out_sat, in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_sum(2, 2, 2, 2);
   endtask

   task automatic test_back_to_back();
      for (int t = 0; t < 4; t++) begin
         for (int k = 0; k < 4; k++) begin
            send_op(int'($urandom_range(0, 15)));
         end
         collect();
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      clear     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 4'd0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      test_sum(1, 2, 3, 4);
      test_sum(3, 5, 7, 9);
      test_sum(15, 15, 15, 15);
      test_backpressure();
      test_clear();
      test_async_reset();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
